// File: rtl/reset_sequencer.sv
// Reset release sequencer: waits for a stable synchronized PLL lock, then releases
// the downstream domain resets one at a time and watches for lock loss or timeout.
module reset_sequencer #(
  parameter int NUM_DOMAINS        = 4,
  parameter int LOCK_STABLE_CYCLES = 16,
  parameter int STAGE_DELAY        = 8,
  parameter int LOCK_TIMEOUT       = 1024,
  parameter int SW_RST_HOLD        = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pll_locked,
  input  logic                   sw_rst_req,
  output logic [NUM_DOMAINS-1:0] domain_rst_n,
  output logic                   seq_done,
  output logic                   lock_fault,
  output logic [2:0]             seq_state
);

  typedef enum logic [2:0] {
    S_RESET_HOLD = 3'd0,
    S_WAIT_LOCK  = 3'd1,
    S_RELEASE    = 3'd2,
    S_RUN        = 3'd3,
    S_FAULT      = 3'd4
  } state_t;

  localparam int HW = $clog2(SW_RST_HOLD + 1);
  localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int GW = $clog2(STAGE_DELAY + 1);
  localparam int DW = $clog2(NUM_DOMAINS + 1);

  localparam logic [HW-1:0] HOLD_LAST  = HW'(SW_RST_HOLD - 1);
  localparam logic [SW-1:0] STAB_LAST  = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [SW-1:0] STAB_MAX   = SW'(LOCK_STABLE_CYCLES);
  localparam logic [TW-1:0] TMO_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_MAX    = TW'(LOCK_TIMEOUT);
  localparam logic [GW-1:0] STAGE_LAST = GW'(STAGE_DELAY - 1);
  localparam logic [DW-1:0] DOM_LAST   = DW'(NUM_DOMAINS - 1);

  logic lock_m, lock_s;

  state_t                 state, state_next;
  logic [HW-1:0]          hold_cnt, hold_next;
  logic [SW-1:0]          stab_cnt, stab_next;
  logic [TW-1:0]          tmo_cnt, tmo_next;
  logic [GW-1:0]          stage_cnt, stage_next;
  logic [DW-1:0]          dom_idx, dom_next;
  logic [NUM_DOMAINS-1:0] rst_next;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would turn the 2-flop synchronizer into one flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_locked;
      lock_s <= lock_m;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_RESET_HOLD;
      hold_cnt     <= '0;
      stab_cnt     <= '0;
      tmo_cnt      <= '0;
      stage_cnt    <= '0;
      dom_idx      <= '0;
      domain_rst_n <= '0;
      seq_done     <= 1'b0;
      lock_fault   <= 1'b0;
    end else begin
      state        <= state_next;
      hold_cnt     <= hold_next;
      stab_cnt     <= stab_next;
      tmo_cnt      <= tmo_next;
      stage_cnt    <= stage_next;
      dom_idx      <= dom_next;
      domain_rst_n <= rst_next;
      seq_done     <= (state_next == S_RUN);
      lock_fault   <= (state_next == S_FAULT);
    end
  end

  assign seq_state = state;

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    stab_next  = stab_cnt;
    tmo_next   = tmo_cnt;
    stage_next = stage_cnt;
    dom_next   = dom_idx;
    rst_next   = domain_rst_n;

    case (state)
      S_RESET_HOLD: begin
        rst_next   = '0;
        stab_next  = '0;
        tmo_next   = '0;
        stage_next = '0;
        dom_next   = '0;
        if (hold_cnt == HOLD_LAST) begin
          state_next = S_WAIT_LOCK;
          hold_next  = '0;
        end else begin
          hold_next = hold_cnt + 1'b1;
        end
      end

      S_WAIT_LOCK, S_FAULT: begin
        rst_next  = '0;
        stab_next = !lock_s ? '0 : (stab_cnt == STAB_MAX) ? stab_cnt : stab_cnt + 1'b1;
        if (state == S_WAIT_LOCK && tmo_cnt != TMO_MAX) tmo_next = tmo_cnt + 1'b1;
        // Stability is tested first so it wins a tie with the timeout.
        if (lock_s && stab_cnt == STAB_LAST) begin
          state_next = S_RELEASE;
          stage_next = '0;
          dom_next   = '0;
        end else if (state == S_WAIT_LOCK && tmo_cnt == TMO_LAST) begin
          state_next = S_FAULT;
        end
      end

      S_RELEASE: begin
        if (stage_cnt == STAGE_LAST) begin
          stage_next = '0;
          dom_next   = dom_idx + 1'b1;
          for (int k = 0; k < NUM_DOMAINS; k++) begin
            if (dom_idx == DW'(k)) rst_next[k] = 1'b1;
          end
          if (dom_idx == DOM_LAST) state_next = S_RUN;
        end else begin
          stage_next = stage_cnt + 1'b1;
        end
      end

      S_RUN: rst_next = '1;

      default: begin
        state_next = S_RESET_HOLD;
        hold_next  = '0;
        rst_next   = '0;
      end
    endcase

    // Aborts override the normal transitions; all resets drop together.
    if (sw_rst_req || (!lock_s && (state == S_RELEASE || state == S_RUN))) begin
      state_next = S_RESET_HOLD;
      hold_next  = '0;
      stab_next  = '0;
      tmo_next   = '0;
      stage_next = '0;
      dom_next   = '0;
      rst_next   = '0;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: an edge-indexed reference model feeds a scoreboard
// checked every cycle, plus directed timing checks on the key sequence edges.
module tb_reset_sequencer;

  localparam int ND = 4;
  localparam int LOCK_STABLE = 16;
  localparam int STAGE_D = 8;
  localparam int LOCK_TMO = 1024;
  localparam int HOLD = 4;

  logic          clk;
  logic          rst_n;
  logic          pll_locked;
  logic          sw_rst_req;
  logic [ND-1:0] domain_rst_n;
  logic          seq_done;
  logic          lock_fault;
  logic [2:0]    seq_state;

  reset_sequencer #(
    .NUM_DOMAINS(ND), .LOCK_STABLE_CYCLES(LOCK_STABLE), .STAGE_DELAY(STAGE_D),
    .LOCK_TIMEOUT(LOCK_TMO), .SW_RST_HOLD(HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .sw_rst_req(sw_rst_req),
    .domain_rst_n(domain_rst_n), .seq_done(seq_done), .lock_fault(lock_fault),
    .seq_state(seq_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phases with edge-number arithmetic; pushes one expected
  // output word per clock edge.
  typedef enum int {M_HOLD = 0, M_WAIT = 1, M_REL = 2, M_RUN = 3, M_FAULT = 4} mph_t;
  typedef struct packed {
    logic [2:0]    st;
    logic [ND-1:0] dom;
    logic          done;
    logic          fault;
  } exp_t;

  exp_t sb[$];
  mph_t m_ph  = M_HOLD;
  int   m_e   = 0;
  int   m_t0  = 0;
  int   m_run = 0;
  logic m_s1  = 1'b0;
  logic m_s2  = 1'b0;

  always @(posedge clk) begin
    logic lock_now;
    exp_t e;
    int   n;
    m_e++;
    lock_now = m_s2;
    m_s2 = m_s1;
    m_s1 = pll_locked;
    if (!rst_n) begin
      m_s1 = 1'b0; m_s2 = 1'b0;
      m_ph = M_HOLD; m_t0 = m_e; m_run = 0;
    end else if (sw_rst_req || (!lock_now && (m_ph == M_REL || m_ph == M_RUN))) begin
      m_ph = M_HOLD; m_t0 = m_e;
    end else begin
      case (m_ph)
        M_HOLD: if (m_e - m_t0 == HOLD) begin m_ph = M_WAIT; m_t0 = m_e; m_run = 0; end
        M_WAIT, M_FAULT: begin
          m_run = lock_now ? m_run + 1 : 0;
          if (m_run == LOCK_STABLE) begin m_ph = M_REL; m_t0 = m_e; end
          else if (m_ph == M_WAIT && m_e - m_t0 == LOCK_TMO) m_ph = M_FAULT;
        end
        M_REL: if ((m_e - m_t0) / STAGE_D >= ND) m_ph = M_RUN;
        default: ;
      endcase
    end
    e.st    = 3'(int'(m_ph));
    n       = (m_ph == M_REL) ? (m_e - m_t0) / STAGE_D : 0;
    e.dom   = (m_ph == M_RUN) ? '1 : ND'((1 << n) - 1);
    e.done  = (m_ph == M_RUN);
    e.fault = (m_ph == M_FAULT);
    sb.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("cycle", 32'({seq_state, domain_rst_n, seq_done, lock_fault}), 32'(e));
    end
  end

  int ecnt = 0;

  task automatic step();
    @(posedge clk);
    #1;
    ecnt++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    ecnt  = 0;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return seq_done;
      1:       return domain_rst_n[0];
      2:       return lock_fault;
      3:       return !lock_fault;
      default: return !seq_done;
    endcase
  endfunction

  // Bounded wait; returns -1 when the limit expires so the caller's check fails.
  task automatic wait_sig(input int which, input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      step();
      if (sig(which)) begin
        at = ecnt;
        break;
      end
    end
  endtask

  initial begin
    int at, mark;
    rst_n = 1'b0; pll_locked = 1'b1; sw_rst_req = 1'b0;

    // Nominal sequence with lock present from the start.
    do_reset();
    check("reset_state", 32'({seq_state, domain_rst_n, seq_done, lock_fault}), 32'd0);
    wait_sig(1, 100, at); check("nominal_dom0_edge", at, 28);
    wait_sig(0, 100, at); check("nominal_done_edge", at, 52);
    check("nominal_run_state", 32'(seq_state), 32'd3);

    // One-cycle lock drop in RUN.
    mark = ecnt;
    pll_locked = 1'b0; step(); pll_locked = 1'b1;
    wait_sig(4, 10, at); check("lockloss_abort_delay", at - mark, 3);
    check("lockloss_outputs", 32'({seq_state, domain_rst_n}), 32'd0);
    mark = at;
    wait_sig(0, 100, at); check("lockloss_rerun", at - mark, 52);

    // Software reset after domain 1 is released.
    do_reset();
    while (ecnt < 38) step();
    check("sw_pre_dom", 32'(domain_rst_n), 32'h3);
    sw_rst_req = 1'b1; step(); sw_rst_req = 1'b0;
    check("sw_abort_outputs", 32'({seq_state, domain_rst_n, seq_done}), 32'd0);
    mark = ecnt;
    wait_sig(0, 100, at); check("sw_rerun", at - mark, 52);

    // Synchronous reset in RUN.
    rst_n = 1'b0; step();
    check("rst_in_run", 32'({seq_state, domain_rst_n, seq_done, lock_fault}), 32'd0);
    rst_n = 1'b1; ecnt = 0;
    wait_sig(0, 100, at); check("rst_rerun", at, 52);

    // Lock glitch after 10 stable cycles in WAIT_LOCK.
    do_reset();
    while (ecnt < 12) step();
    pll_locked = 1'b0; step(); pll_locked = 1'b1;
    wait_sig(1, 100, at); check("glitch_dom0_edge", at, 39);
    wait_sig(0, 100, at); check("glitch_done_edge", at, 63);

    // Lock timeout, then recovery from FAULT.
    pll_locked = 1'b0;
    do_reset();
    wait_sig(2, 1100, at); check("timeout_edge", at, 1028);
    check("fault_state", 32'(seq_state), 32'd4);
    pll_locked = 1'b1;
    mark = ecnt;
    wait_sig(3, 40, at); check("fault_clear_delay", at - mark, 18);
    check("fault_to_release", 32'(seq_state), 32'd2);
    wait_sig(0, 100, at); check("fault_done_delay", at - mark, 50);

    // Random traffic; the scoreboard checks every cycle.
    for (int it = 0; it < 80; it++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 8) begin
        sw_rst_req = 1'b1;
        repeat (int'($urandom_range(1, 3))) step();
        sw_rst_req = 1'b0;
      end else if (r < 11) begin
        rst_n = 1'b0; step(); rst_n = 1'b1;
      end else begin
        pll_locked = ($urandom_range(0, 3) != 0);
        repeat (int'($urandom_range(1, 60))) step();
      end
    end
    pll_locked = 1'b1;
    repeat (80) step();
    check("final_run", 32'(seq_done), 32'd1);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Sequences reset release for up to NUM_DOMAINS downstream domains, in order, after the reference PLL reports stable lock.
- Sits in the clock/reset infrastructure next to the per-domain reset synchronizers. Each domain_rst_n bit drives the async_rst_n of that domain's reset synchronizer.
- Detects lock loss and lock timeout. Accepts a software reset request that re-runs the whole sequence.

Parameters:
- NUM_DOMAINS, 4, number of sequenced reset outputs (1..16).
- LOCK_STABLE_CYCLES, 16, consecutive synchronized-lock-high cycles required before release (>=1).
- STAGE_DELAY, 8, cycles between successive domain releases (>=1).
- LOCK_TIMEOUT, 1024, cycles allowed in WAIT_LOCK before declaring a fault (>LOCK_STABLE_CYCLES).
- SW_RST_HOLD, 4, minimum cycles all outputs stay asserted after any (re)entry to RESET_HOLD (>=3).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- pll_locked  in  1  PLL lock, asynchronous to clk.
- sw_rst_req  in  1  software reset request, single-cycle pulse or level, clk domain.
- domain_rst_n  out  NUM_DOMAINS  per-domain reset, active-low; bit 0 released first.
- seq_done  out  1  high while in RUN.
- lock_fault  out  1  high while in FAULT.
- seq_state  out  3  encoded state: RESET_HOLD=0, WAIT_LOCK=1, RELEASE=2, RUN=3, FAULT=4.

Behaviour:
- All outputs are registered.
- Reset (rst_n low at a rising edge):
  - state=RESET_HOLD; all counters 0.
  - domain_rst_n=all 0; seq_done=0; lock_fault=0; seq_state=0.
  - Lock synchronizer flops cleared to 0.
- Lock input:
  - pll_locked passes through a 2-flop synchronizer → lock_s.
  - Latency is 2 cycles. No other use of raw pll_locked.
- RESET_HOLD:
  - All domain_rst_n=0.
  - Hold counter counts SW_RST_HOLD cycles, then → WAIT_LOCK.
  - Stability and timeout counters are cleared.
- WAIT_LOCK:
  - Stability counter increments when lock_s=1 and clears to 0 when lock_s=0.
  - Timeout counter increments every cycle.
  - Stability reaching LOCK_STABLE_CYCLES → RELEASE. This is checked before timeout, so stability wins if both reach their limits in the same cycle.
  - Otherwise timeout reaching LOCK_TIMEOUT → FAULT.
- FAULT:
  - lock_fault=1; all resets stay asserted.
  - Stability counting continues as in WAIT_LOCK.
  - When stability is reached → RELEASE; lock_fault clears on the same edge.
- RELEASE:
  - Stage counter counts STAGE_DELAY cycles per domain.
  - domain_rst_n[k] goes high on the edge that ends (k+1)*STAGE_DELAY cycles in RELEASE. Bits already released stay high.
  - The edge releasing bit NUM_DOMAINS-1 also enters RUN and sets seq_done=1.
- RUN:
  - All domain_rst_n=1; seq_done=1.
- Abort conditions, evaluated every cycle:
  - lock_s=0 while in RELEASE or RUN → RESET_HOLD.
  - sw_rst_req=1 in any state → RESET_HOLD, with lock_fault cleared.
  - On the abort edge, all domain_rst_n=0 and seq_done=0 at the same time, with no staged assertion.
  - sw_rst_req held high keeps the block in RESET_HOLD. The hold count restarts each cycle it is high.
- Priority, highest first: rst_n, sw_rst_req, lock loss, normal transitions.
- Counter widths: $clog2(param+1). Counters saturate and never wrap.
- Undefined encodings of the state register → RESET_HOLD.
- Nominal sequence time: with lock_s already high on entry to WAIT_LOCK, seq_done rises SW_RST_HOLD + LOCK_STABLE_CYCLES + NUM_DOMAINS*STAGE_DELAY edges after the first edge with rst_n=1.

Test Plan:
- Defaults; pll_locked=1 from time 0; release rst_n
  - domain_rst_n[0] rises at edge 28, then bits 1..3 at edges 36, 44, 52.
  - seq_done=1 at edge 52; seq_state steps 0→1→2→3.
- Defaults; pll_locked=0 throughout
  - seq_state=4 and lock_fault=1 at edge 4+1024=1028.
  - Then drive pll_locked=1 → lock_fault clears 2+16 cycles later; state=RELEASE; normal staged release follows.
- In RUN, drop pll_locked for 1 cycle
  - 2 cycles later all domain_rst_n=0 and seq_done=0 on one edge; state=0.
  - Full sequence reruns; seq_done returns after 52 edges.
- Lock glitch in WAIT_LOCK: pll_locked low for 1 cycle after 10 stable cycles
  - Stability restarts; release is delayed by exactly 11 cycles versus the nominal run.
- sw_rst_req pulse mid-RELEASE, after domain 1 has been released
  - Next edge: domain_rst_n=0000, state=0. Rerun completes in 52 edges.
- rst_n asserted low mid-RUN for 1 cycle
  - All outputs return to their reset values on that edge.
  - Sequence restarts with the pll_locked synchronizer cleared, so seq_done lags by an extra 0 cycles because the hold of 4 covers the 2-cycle sync latency.
